// File: rtl/byte_serializer.sv
`default_nettype none
// ============================================================================
// Module      : byte_serializer
// Description : Accepts one NBYTES-wide word per valid/ready handshake and
//               emits its bytes one per cycle on a valid/ready byte stream.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_serializer #(
  parameter int NBYTES    = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [8*NBYTES-1:0]       in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                out_data,
  output logic [$clog2(NBYTES)-1:0] out_idx,
  output logic                      out_last,
  output logic [CNT_W-1:0]          word_cnt
);

  localparam int                 IDX_W      = $clog2(NBYTES);
  localparam logic [IDX_W-1:0]   c_LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t               r_state;
  logic [8*NBYTES-1:0]  r_buf;
  logic [IDX_W-1:0]     r_idx;
  logic [CNT_W-1:0]     r_cnt;

  logic [7:0]           w_bytes [NBYTES];
  logic                 w_send;
  logic                 w_last;
  logic                 w_in_ready;
  logic                 w_accept;

  // w_bytes[i] is the i-th byte in transmit order, so the output mux is order-agnostic.
  generate
    for (genvar g = 0; g < NBYTES; g++) begin : g_order
      if (MSB_FIRST) begin : g_msb
        assign w_bytes[g] = r_buf[8*(NBYTES-g)-1 -: 8];
      end else begin : g_lsb
        assign w_bytes[g] = r_buf[8*g+7 -: 8];
      end
    end
  endgenerate

  assign w_send     = (r_state == ST_SEND);
  assign w_last     = w_send && (r_idx == c_LAST_IDX);
  // A new word may land on the same edge the final byte leaves: no bubble.
  assign w_in_ready = reset_n && (!w_send || (out_ready && w_last));
  assign w_accept   = in_valid && w_in_ready;

  assign in_ready  = w_in_ready;
  assign out_valid = w_send;
  assign out_data  = w_send ? w_bytes[r_idx] : 8'h00;
  assign out_idx   = r_idx;
  assign out_last  = w_last;
  assign word_cnt  = r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_buf   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_buf   <= in_data;
            r_idx   <= '0;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            if (!w_last) begin
              r_idx <= r_idx + IDX_W'(1);
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
              r_idx <= '0;
              if (w_accept) begin
                r_buf <= in_data;
              end else begin
                r_state <= ST_IDLE;
              end
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_idx   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
